linear_pars_rd_ctrl: RTL and testbench
======================================

Name: linear_pars_rd_ctrl

Overview:
- Controller that sequences the linear-parameter buffer (per-kernel A/B, 2-stage MEM read: ren_s0 then ren_s1) for the conv post-processing path.
- Per block it pulses the buffer reset, waits for the A and B loads to complete, then streams conv results. Each result beat is paired with its kernel's A and B, read at address = output-channel index.
- Sits between the conv accumulator output and the AX+B unit. Owns the buffer's read port exclusively.

Parameters:
- data_width, 32, conv result width (bits)
- kernal_param_data_width, 16, A/B width (8|16|32|64)
- max_kernal_n, 512, max output channels; counter width = clog2(max_kernal_n)
- simulation_delay, 1, sim-only delay on register assignments

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- blk_start  in  1  start pulse; accepted only in IDLE
- blk_idle  out  1  high in IDLE
- blk_done  out  1  1-cycle pulse when the block has fully drained
- cfg_kernal_n  in  16  channel count minus 1 (0 → 1 channel); sampled at blk_start
- rst_linear_pars_buf  out  1  to the buffer; 1-cycle pulse
- linear_pars_buf_load_completed  in  1  from the buffer
- linear_pars_buffer_ren_s0  out  1  MEM read enable
- linear_pars_buffer_ren_s1  out  1  output-register enable
- linear_pars_buffer_raddr  out  16  channel index, zero-extended
- linear_pars_buffer_dout_a  in  kernal_param_data_width  A
- linear_pars_buffer_dout_b  in  kernal_param_data_width  B
- s_axis_res_data  in  data_width  conv result
- s_axis_res_last  in  1  last beat of the current output channel
- s_axis_res_valid  in  1
- s_axis_res_ready  out  1
- m_axis_res_data  out  data_width
- m_axis_res_par_a  out  kernal_param_data_width
- m_axis_res_par_b  out  kernal_param_data_width
- m_axis_res_last  out  1  last beat of the last channel of the block
- m_axis_res_valid  out  1
- m_axis_res_ready  in  1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; channel counter = 0; pipeline valids = 0.
  - Outputs: blk_idle=1; blk_done=0; rst_linear_pars_buf=0; ren_s0=0; ren_s1=0; s_axis_res_ready=0; m_axis_res_valid=0; m_axis_res_last=0.
  - Reset mid-block aborts immediately; data in the pipeline is discarded.
- FSM states: IDLE → RST_BUF → WAIT_LOAD → RUN → DRAIN → IDLE.
  - IDLE: on blk_start, latch cfg_kernal_n, clear the channel counter, go to RST_BUF.
  - RST_BUF: exactly 1 cycle; rst_linear_pars_buf=1.
  - WAIT_LOAD: stay until load_completed=1. It is sampled no earlier than the cycle after RST_BUF, so a stale 1 is never used.
  - RUN: ends on acceptance of the beat with s_axis_res_last=1 while channel counter == latched cfg_kernal_n; go to DRAIN.
  - DRAIN: stay until both pipeline stages are empty, then pulse blk_done for 1 cycle and return to IDLE.
  - blk_start outside IDLE is ignored.
- Channel counter:
  - Increments on each accepted beat with last=1.
  - Wraps to 0 after cfg_kernal_n.
  - raddr = counter value at the accept cycle.
- Pipeline: two stages.
  - P0 holds the accepted beat while the MEM read is in flight.
  - P1 holds the beat while the buffer output register is valid.
  - advance = ~p1_vld | m_axis_res_ready.
  - s_axis_res_ready = advance & (state==RUN).
  - ren_s0 = s_axis_res_valid & s_axis_res_ready.
  - ren_s1 = advance & p0_vld.
  - P0 loads/clears only when advance=1; P1 loads from P0 when advance=1.
- Latency: beat accepted at cycle t is presented on m_axis at t+2 when there is no backpressure. Full throughput: 1 beat/cycle.
- Stall: when advance=0, neither ren is asserted. The buffer MEM output and output register hold their values, so A/B remain aligned with P1 indefinitely.
- m_axis outputs:
  - m_axis_res_par_a/par_b wire straight from dout_a/dout_b.
  - m_axis_res_data and m_axis_res_last come from P1.
  - m_axis_res_last = last & (channel == cfg_kernal_n), captured at accept.
- Masking of invalid parameters (zeroed A/B) is done by the buffer; this block is transparent to it.

Decomposition:
- Shared package: FSM state encoding (IDLE, RST_BUF, WAIT_LOAD, RUN, DRAIN) and the clogb2 width function.
- One natural sub-module: linear_pars_rd_pipe. It holds the 2-stage valid/data pipeline and the ren generation.
- The FSM and channel counter stay in the top level.

Test Plan:
- Idle/reset: rst_n low 2 cycles mid-RUN with beats in flight → next cycle blk_idle=1, m_axis_res_valid=0, ren_s0=ren_s1=0; no blk_done.
- Load gating: blk_start, load_completed held 0 for 10 cycles → rst_linear_pars_buf is one 1-cycle pulse, s_axis_res_ready=0 throughout; raise load_completed → ready next cycle.
- Streaming, A[k]=k+1, B[k]=0x100+k: cfg_kernal_n=3, 4 beats/channel, no stalls → 16 outputs at 1/cycle; beat in channel k carries A=k+1, B=0x100+k; first output 2 cycles after first accept; last=1 only on beat 16.
- Backpressure: random m_axis_res_ready at 30% → no loss or duplication; A/B stay aligned with data under stalls of 1–20 cycles.
- Single channel: cfg_kernal_n=0, 1 beat with last=1 → raddr=0, one output with last=1, blk_done 1 cycle after the output handshake.
- Restart: blk_start during RUN ignored; second blk_start after blk_done with cfg_kernal_n=1 → counter restarts at 0, raddr sequence 0,1.

Source files
------------

// File: rtl/linear_pars_rd_ctrl_pkg.sv
// Shared definitions for the linear-parameter buffer read controller:
// FSM state encoding and the counter-width helper.
package linear_pars_rd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_BUF,
      ST_WAIT_LOAD,
      ST_RUN,
      ST_DRAIN
   } state_t;

   // Bits needed to index 0..depth-1; never narrower than one bit.
   function automatic int clogb2(input int depth);
      int w;
      w = 0;
      while ((1 << w) < depth) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/linear_pars_rd_pipe.sv
// Two-stage beat pipeline that tracks the buffer's MEM read (P0) and its
// output register (P1), and generates the matching read enables.
module linear_pars_rd_pipe
   import linear_pars_rd_ctrl_pkg::*;
#(
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic [data_width-1:0] s_data,
   input  logic                  s_last,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  ren_s0,
   output logic                  ren_s1,
   output logic [data_width-1:0] m_data,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  empty
);

   logic                  advance;
   logic                  p0_vld_reg;
   logic                  p1_vld_reg;
   logic                  p0_last_reg;
   logic                  p1_last_reg;
   logic [data_width-1:0] p0_data_reg;
   logic [data_width-1:0] p1_data_reg;

   // Both stages move together, so the buffer's read stages stay in lock-step with P0/P1.
   assign advance = ~p1_vld_reg | m_ready;
   assign s_ready = advance & run;
   assign ren_s0  = s_valid & s_ready;
   assign ren_s1  = advance & p0_vld_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p0_vld_reg  <= 1'b0;
         p1_vld_reg  <= 1'b0;
         p0_last_reg <= 1'b0;
         p1_last_reg <= 1'b0;
      end else if (advance) begin
         p0_vld_reg  <= ren_s0;
         p1_vld_reg  <= p0_vld_reg;
         p0_last_reg <= s_last & ren_s0;
         p1_last_reg <= p0_last_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         p0_data_reg <= s_data;
         p1_data_reg <= p0_data_reg;
      end
   end

   assign m_data  = p1_data_reg;
   assign m_last  = p1_last_reg;
   assign m_valid = p1_vld_reg;
   assign empty   = ~p0_vld_reg & ~p1_vld_reg;

endmodule

// File: rtl/linear_pars_rd_ctrl.sv
// Sequences the linear-parameter buffer per block (reset, wait for load, stream)
// and pairs each conv result beat with its kernel's A/B parameters.
module linear_pars_rd_ctrl
   import linear_pars_rd_ctrl_pkg::*;
#(
   parameter int data_width              = 32,
   parameter int kernal_param_data_width = 16,
   parameter int max_kernal_n            = 512,
   parameter int simulation_delay        = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               blk_start,
   output logic                               blk_idle,
   output logic                               blk_done,
   input  logic [15:0]                        cfg_kernal_n,
   output logic                               rst_linear_pars_buf,
   input  logic                               linear_pars_buf_load_completed,
   output logic                               linear_pars_buffer_ren_s0,
   output logic                               linear_pars_buffer_ren_s1,
   output logic [15:0]                        linear_pars_buffer_raddr,
   input  logic [kernal_param_data_width-1:0] linear_pars_buffer_dout_a,
   input  logic [kernal_param_data_width-1:0] linear_pars_buffer_dout_b,
   input  logic [data_width-1:0]              s_axis_res_data,
   input  logic                               s_axis_res_last,
   input  logic                               s_axis_res_valid,
   output logic                               s_axis_res_ready,
   output logic [data_width-1:0]              m_axis_res_data,
   output logic [kernal_param_data_width-1:0] m_axis_res_par_a,
   output logic [kernal_param_data_width-1:0] m_axis_res_par_b,
   output logic                               m_axis_res_last,
   output logic                               m_axis_res_valid,
   input  logic                               m_axis_res_ready
);

   localparam int cnt_w = clogb2(max_kernal_n);

   state_t             state_reg;
   state_t             state_next;
   logic [15:0]        kernal_n_reg;
   logic [cnt_w-1:0]   cnt_reg;
   logic [cnt_w-1:0]   cnt_next;
   logic               at_end;
   logic               last_acc;
   logic               pipe_empty;

   // Registers update without delay; a negative simulation_delay has no meaning here.
   if (simulation_delay < 0) begin : g_neg_sim_delay
   end

   assign at_end   = (16'(cnt_reg) == kernal_n_reg);
   assign last_acc = linear_pars_buffer_ren_s0 & s_axis_res_last;

   always_comb begin
      state_next          = state_reg;
      cnt_next            = cnt_reg;
      blk_idle            = 1'b0;
      blk_done            = 1'b0;
      rst_linear_pars_buf = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            blk_idle = 1'b1;
            if (blk_start) begin
               state_next = ST_RST_BUF;
               cnt_next   = '0;
            end
         end
         ST_RST_BUF: begin
            rst_linear_pars_buf = 1'b1;
            state_next          = ST_WAIT_LOAD;
         end
         ST_WAIT_LOAD: begin
            if (linear_pars_buf_load_completed) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (last_acc) begin
               cnt_next = at_end ? '0 : cnt_reg + cnt_w'(1);
               if (at_end) state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               blk_done   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         kernal_n_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == ST_IDLE && blk_start) kernal_n_reg <= cfg_kernal_n;
      end
   end

   assign linear_pars_buffer_raddr = 16'(cnt_reg);

   linear_pars_rd_pipe #(
      .data_width (data_width)
   ) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_reg == ST_RUN),
      .s_data  (s_axis_res_data),
      .s_last  (s_axis_res_last & at_end),
      .s_valid (s_axis_res_valid),
      .s_ready (s_axis_res_ready),
      .ren_s0  (linear_pars_buffer_ren_s0),
      .ren_s1  (linear_pars_buffer_ren_s1),
      .m_data  (m_axis_res_data),
      .m_last  (m_axis_res_last),
      .m_valid (m_axis_res_valid),
      .m_ready (m_axis_res_ready),
      .empty   (pipe_empty)
   );

   // The buffer's output register is kept aligned with P1, so A/B pass straight through.
   assign m_axis_res_par_a = linear_pars_buffer_dout_a;
   assign m_axis_res_par_b = linear_pars_buffer_dout_b;

endmodule

// File: tb/tb_linear_pars_rd_ctrl.sv
// Self-checking bench for linear_pars_rd_ctrl: block runs from a vector table,
// a two-stage buffer model with A[k]=k+1, B[k]=0x100+k, and a beat scoreboard.
module tb_linear_pars_rd_ctrl;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] a;
      logic [15:0] b;
      logic        last;
   } beat_t;

   typedef struct {
      int kn;
      int bpc;
      int ready_pct;
      int load_dly;
      int poke;
      int exp;
   } blk_vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        blk_start = 1'b0;
   logic        blk_idle;
   logic        blk_done;
   logic [15:0] cfg_kernal_n = '0;
   logic        rst_linear_pars_buf;
   logic        load_completed = 1'b0;
   logic        ren_s0;
   logic        ren_s1;
   logic [15:0] raddr;
   logic [15:0] dout_a = '0;
   logic [15:0] dout_b = '0;
   logic [15:0] mq_a = '0;
   logic [15:0] mq_b = '0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] m_data;
   logic [15:0] m_par_a;
   logic [15:0] m_par_b;
   logic        m_last;
   logic        m_valid;
   logic        m_ready = 1'b1;

   int    n_cmp = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    ready_pct = 100;
   int    n_out, n_last, n_acc, done_cnt, done_cyc, rst_pulses;
   int    first_acc_cyc, first_vld_cyc, last_out_cyc;
   bit    vld_seen;
   beat_t sb[$];
   beat_t got, want;
   blk_vec_t vec[6];

   linear_pars_rd_ctrl dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .blk_start                      (blk_start),
      .blk_idle                       (blk_idle),
      .blk_done                       (blk_done),
      .cfg_kernal_n                   (cfg_kernal_n),
      .rst_linear_pars_buf            (rst_linear_pars_buf),
      .linear_pars_buf_load_completed (load_completed),
      .linear_pars_buffer_ren_s0      (ren_s0),
      .linear_pars_buffer_ren_s1      (ren_s1),
      .linear_pars_buffer_raddr       (raddr),
      .linear_pars_buffer_dout_a      (dout_a),
      .linear_pars_buffer_dout_b      (dout_b),
      .s_axis_res_data                (s_data),
      .s_axis_res_last                (s_last),
      .s_axis_res_valid               (s_valid),
      .s_axis_res_ready               (s_ready),
      .m_axis_res_data                (m_data),
      .m_axis_res_par_a               (m_par_a),
      .m_axis_res_par_b               (m_par_b),
      .m_axis_res_last                (m_last),
      .m_axis_res_valid               (m_valid),
      .m_axis_res_ready               (m_ready)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model: MEM stage on ren_s0, output register on ren_s1, both hold otherwise.
   always @(posedge clk) begin
      if (ren_s0) begin
         mq_a <= 16'(raddr + 16'd1);
         mq_b <= 16'(raddr + 16'h100);
      end
      if (ren_s1) begin
         dout_a <= mq_a;
         dout_b <= mq_b;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
   end

   function automatic void chk_i(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_beat(input beat_t act, input beat_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL beat: got data=%h a=%h b=%h last=%0b expected data=%h a=%h b=%h last=%0b",
                  act.data, act.a, act.b, act.last, exp.data, exp.a, exp.b, exp.last);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_linear_pars_buf) rst_pulses++;
      if (blk_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (m_valid && !vld_seen) begin
         vld_seen      = 1'b1;
         first_vld_cyc = cyc;
      end
      if (m_valid && m_ready) begin
         got = '{data: m_data, a: m_par_a, b: m_par_b, last: m_last};
         $display("out %0d: data=%h a=%h b=%h last=%0b", n_out, m_data, m_par_a, m_par_b, m_last);
         last_out_cyc = cyc;
         n_out++;
         if (m_last) n_last++;
         chk_i("sb_has_entry", int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            want = sb.pop_front();
            chk_beat(got, want);
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic l, input int k, input logic blast);
      int    t;
      beat_t e;
      t       = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      while (!s_ready && t < 200) begin
         t++;
         @(negedge clk);
      end
      chk_i("s_ready", int'(s_ready), 1);
      if (s_ready) begin
         if (n_acc == 0) first_acc_cyc = cyc;
         n_acc++;
         chk_i("raddr", int'(raddr), k);
         chk_i("ren_s0", int'(ren_s0), 1);
         e.data = d;
         e.a    = 16'(k + 1);
         e.b    = 16'(k + 'h100);
         e.last = blast;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic run_block(input blk_vec_t v, input int idx);
      int t;
      int ready_seen;
      sb.delete();
      n_out = 0; n_last = 0; n_acc = 0; done_cnt = 0; rst_pulses = 0; vld_seen = 1'b0;
      ready_pct      = v.ready_pct;
      cfg_kernal_n   = 16'(v.kn);
      load_completed = 1'b0;
      blk_start      = 1'b1;
      @(posedge clk);
      #1;
      blk_start  = 1'b0;
      ready_seen = 0;
      for (int i = 0; i < v.load_dly; i++) begin
         @(negedge clk);
         if (s_ready) ready_seen++;
         @(posedge clk);
         #1;
      end
      chk_i("ready_while_loading", ready_seen, 0);
      chk_i("rst_buf_pulses", rst_pulses, 1);
      load_completed = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_i("ready_after_load", int'(s_ready), 1);
      @(posedge clk);
      #1;
      for (int k = 0; k <= v.kn; k++) begin
         for (int j = 0; j < v.bpc; j++) begin
            if (v.poke != 0 && k == 0 && j == 1) begin
               blk_start    = 1'b1;
               cfg_kernal_n = 16'd9;
            end
            send_beat(32'((idx << 24) | (k << 8) | j), (j == v.bpc - 1), k,
                      (j == v.bpc - 1) && (k == v.kn));
            blk_start    = 1'b0;
            cfg_kernal_n = 16'(v.kn);
         end
      end
      t = 0;
      while (done_cnt == 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk_i("blk_done_pulses", done_cnt, 1);
      chk_i("done_after_last_hs", done_cyc - last_out_cyc, 1);
      chk_i("out_count", n_out, v.exp);
      chk_i("last_count", n_last, 1);
      chk_i("sb_empty", sb.size(), 0);
      chk_i("latency", first_vld_cyc - first_acc_cyc, 2);
      if (v.ready_pct == 100) chk_i("throughput", last_out_cyc - first_vld_cyc, v.exp - 1);
      chk_i("idle_after", int'(blk_idle), 1);
      $display("block %0d: kn=%0d beats=%0d outputs=%0d", idx, v.kn, v.exp, n_out);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{kn: 3, bpc: 4, ready_pct: 100, load_dly: 10, poke: 0, exp: 16};
      vec[1] = '{kn: 3, bpc: 5, ready_pct: 30,  load_dly: 2,  poke: 0, exp: 20};
      vec[2] = '{kn: 0, bpc: 1, ready_pct: 100, load_dly: 1,  poke: 0, exp: 1};
      vec[3] = '{kn: 1, bpc: 2, ready_pct: 100, load_dly: 1,  poke: 1, exp: 4};
      vec[4] = '{kn: 1, bpc: 3, ready_pct: 30,  load_dly: 3,  poke: 0, exp: 6};
      vec[5] = '{kn: 7, bpc: 2, ready_pct: 60,  load_dly: 1,  poke: 0, exp: 16};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_i("reset_outputs",
            int'({blk_idle, blk_done, rst_linear_pars_buf, ren_s0, ren_s1, s_ready, m_valid, m_last}),
            int'(8'b1000_0000));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) run_block(vec[i], i + 1);

      // Reset while two beats sit in the stalled pipeline.
      done_cnt       = 0;
      ready_pct      = 0;
      m_ready        = 1'b0;
      cfg_kernal_n   = 16'd3;
      load_completed = 1'b0;
      blk_start      = 1'b1;
      @(posedge clk); #1;
      blk_start = 1'b0;
      @(posedge clk); #1;
      load_completed = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = 32'hAAAA_0000;
      s_last  = 1'b0;
      @(posedge clk); #1;
      s_data = 32'hAAAA_0001;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk_i("stall_m_valid", int'(m_valid), 1);
      chk_i("stall_ren_s0", int'(ren_s0), 0);
      chk_i("stall_ren_s1", int'(ren_s1), 0);
      chk_i("stall_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk_i("abort_idle", int'(blk_idle), 1);
      chk_i("abort_m_valid", int'(m_valid), 0);
      chk_i("abort_rens", int'({ren_s0, ren_s1}), 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      ready_pct = 100;
      repeat (5) @(negedge clk);
      chk_i("abort_no_done", done_cnt, 0);
      chk_i("abort_still_idle", int'(blk_idle), 1);
      sb.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
